// File: rtl/cache_control_if.sv
// cache_control_if -- CPU-side and physical-memory-side buses of cache_control.
//
// CPU bus:
//   mem_address[31:0], mem_read, mem_write, mem_byte_enable[3:0], mem_wdata[31:0]
//   mem_rdata[31:0], mem_resp
// Physical memory bus (one 32-byte line per transfer):
//   pmem_address[31:0], pmem_read, pmem_write, pmem_wdata[255:0]
//   pmem_rdata[255:0], pmem_resp
//
// Modports:
//   slave  : the cache (serves the CPU bus, masters the pmem bus)
//   master : the environment (CPU + physical memory)
interface cache_control_if;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_control.sv
// cache_control -- direct-mapped write-back cache, 8 sets x 32-byte lines.
//
// Address split: tag[31:8], index[7:5], word[4:2], byte[1:0].
// Ports:
//   clk   : single clock, all state changes on posedge
//   rst   : synchronous, active-high; clears valid/dirty, returns to CHECK
//   bus   : cache_control_if.slave (CPU request/response + pmem line bus)
//   hit_count, miss_count (32 each) : only when CACHE_PERF_CNT_EN is defined
//
// Optional feature macro: CACHE_PERF_CNT_EN (performance counters).
module cache_control (
  input  logic               clk,
  input  logic               rst,
  cache_control_if.slave     bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state, state_next;

  logic [7:0]   valid_arr;
  logic [7:0]   dirty_arr;
  logic [23:0]  tag_arr  [8];
  logic [255:0] data_arr [8];

  logic [2:0]   idx;
  logic [23:0]  tag_in;
  logic [2:0]   word_sel;
  logic         req;
  logic         is_write;
  logic         hit;
  logic [255:0] merged_line;

  logic         hit_write;
  logic         miss_start;
  logic         wb_done;
  logic         fill_done;

  assign idx      = bus.mem_address[7:5];
  assign tag_in   = bus.mem_address[31:8];
  assign word_sel = bus.mem_address[4:2];
  assign req      = bus.mem_read | bus.mem_write;
  // A simultaneous read+write request is serviced as a write.
  assign is_write = bus.mem_write;
  assign hit      = valid_arr[idx] && (tag_arr[idx] == tag_in);

  // Current line with the enabled CPU bytes merged into the selected word.
  always_comb begin
    merged_line = data_arr[idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.mem_byte_enable[i]) begin
        merged_line[{word_sel, i[1:0], 3'b000} +: 8] = bus.mem_wdata[{i[1:0], 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    state_next       = state;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    hit_write        = 1'b0;
    miss_start       = 1'b0;
    wb_done          = 1'b0;
    fill_done        = 1'b0;

    // Outputs are held quiet during the reset cycle itself.
    if (!rst) begin
      case (state)
        CHECK: begin
          if (req) begin
            if (hit) begin
              bus.mem_resp = 1'b1;
              if (is_write) begin
                hit_write = 1'b1;
              end else begin
                bus.mem_rdata = data_arr[idx][{word_sel, 5'b00000} +: 32];
              end
            end else begin
              miss_start = 1'b1;
              state_next = (valid_arr[idx] && dirty_arr[idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {tag_arr[idx], idx, 5'b00000};
          bus.pmem_wdata   = data_arr[idx];
          if (bus.pmem_resp) begin
            wb_done    = 1'b1;
            state_next = ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {bus.mem_address[31:5], 5'b00000};
          if (bus.pmem_resp) begin
            fill_done  = 1'b1;
            state_next = CHECK;
          end
        end
        default: state_next = CHECK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CHECK;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      state <= state_next;
      if (hit_write) begin
        data_arr[idx]  <= merged_line;
        dirty_arr[idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_arr[idx] <= 1'b0;
      end
      if (fill_done) begin
        data_arr[idx]  <= bus.pmem_rdata;
        tag_arr[idx]   <= tag_in;
        valid_arr[idx] <= 1'b1;
        dirty_arr[idx] <= 1'b0;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // A request that missed completes later through the hit path; miss_pending
  // keeps that completion from also being counted as a hit.
  logic miss_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count    <= '0;
      miss_count   <= '0;
      miss_pending <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_count   <= miss_count + 32'd1;
        miss_pending <= 1'b1;
      end else if (state == CHECK && (bus.mem_resp || !req)) begin
        miss_pending <= 1'b0;
      end
      if (bus.mem_resp && !miss_pending) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control -- scoreboard bench for cache_control.
// The reference is a flat memory (CPU-written words over a physical memory
// image) plus a per-set record of which line is resident and whether it has
// been written, which decides hit/miss and writeback expectations.
module tb_cache_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_control_if bus();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_control dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int unsigned n_pmem;
    bit          hit;
  } resp_t;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } pmem_t;

  resp_t exp_resp[$];
  pmem_t exp_pmem[$];

  logic [31:0]  gold     [int unsigned];
  logic [255:0] pmem_mem [int unsigned];
  bit   [7:0]   m_valid;
  bit   [7:0]   m_dirty;
  logic [26:0]  m_line [8];

  int          checks = 0;
  int          errors = 0;
  int unsigned model_hits = 0;
  int unsigned model_misses = 0;
  int unsigned pmem_done = 0;
  int unsigned pmem_base = 0;
  int unsigned force_lat = 0;
  longint      cyc = 0;
  longint      req_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [31:0] init_word(int unsigned wa);
    return wa * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  function automatic logic [255:0] pmem_line(int unsigned la);
    logic [255:0] l;
    if (pmem_mem.exists(la)) return pmem_mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la * 8 + w);
    return l;
  endfunction

  function automatic logic [31:0] gold_word(int unsigned wa);
    logic [255:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = pmem_line(wa >> 3);
    return l[(wa & 7) * 32 +: 32];
  endfunction

  function automatic logic [255:0] gold_line(int unsigned la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word(la * 8 + w);
    return l;
  endfunction

  // Monitor: CPU responses and bus invariants.
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      chk("pmem_rd_wr_exclusive", 256'(bus.pmem_read && bus.pmem_write), 256'd0);
      if (bus.mem_resp) begin
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=1 required=0");
        end else begin
          r = exp_resp.pop_front();
          if (r.is_read) chk("mem_rdata", 256'(bus.mem_rdata), 256'(r.rdata));
          chk("pmem_txn_count", 256'(pmem_done - pmem_base), 256'(r.n_pmem));
          if (r.hit) chk("hit_latency", 256'(cyc - req_cyc), 256'd0);
          else       chk("miss_latency_min2", 256'((cyc - req_cyc) >= 2), 256'd1);
        end
      end
    end
  end

  // Physical memory responder with scoreboarded request checking.
  initial begin
    pmem_t       e;
    int unsigned lat;
    bit          aborted;
    bit          wr;
    logic [31:0] a;
    logic [255:0] wd;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.pmem_read || bus.pmem_write)) begin
        wr = bus.pmem_write;
        a  = bus.pmem_address;
        wd = bus.pmem_wdata;
        if (exp_pmem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pmem actual=%h required=none", a);
        end else begin
          e = exp_pmem.pop_front();
          chk("pmem_is_write", 256'(wr), 256'(e.is_write));
          chk("pmem_address", 256'(a), 256'(e.addr));
          if (e.is_write) chk("pmem_wdata", wd, e.wdata);
        end
        lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
        aborted = 1'b0;
        for (int k = 0; k < int'(lat); k++) begin
          @(posedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          #1;
          if (wr) pmem_mem[a >> 5] = wd;
          else    bus.pmem_rdata = pmem_line(a >> 5);
          bus.pmem_resp = 1'b1;
          @(posedge clk);
          #1;
          bus.pmem_resp = 1'b0;
          pmem_done++;
        end
      end
    end
  end

  task automatic model_reset();
    m_valid = '0;
    m_dirty = '0;
    gold.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    chk("reset_mem_resp", 256'(bus.mem_resp), 256'd0);
    chk("reset_pmem_req", 256'({bus.pmem_read, bus.pmem_write}), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_reset_outputs", 256'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 256'd0);
  endtask

  task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [3:0] be, input logic [31:0] wdata);
    int unsigned set = addr[7:5];
    int unsigned la  = addr[31:5];
    int unsigned wa  = addr[31:2];
    int unsigned n   = 0;
    int          k   = 0;
    bit          hit;
    resp_t       r;
    pmem_t       p;
    logic [31:0] w;

    hit = m_valid[set] && (m_line[set] == 27'(la));
    if (!hit) begin
      model_misses++;
      if (m_valid[set] && m_dirty[set]) begin
        p.is_write = 1'b1;
        p.addr     = {m_line[set], 5'b00000};
        p.wdata    = gold_line(m_line[set]);
        exp_pmem.push_back(p);
        n++;
      end
      p.is_write = 1'b0;
      p.addr     = {la[26:0], 5'b00000};
      p.wdata    = '0;
      exp_pmem.push_back(p);
      n++;
      m_valid[set] = 1'b1;
      m_dirty[set] = 1'b0;
      m_line[set]  = 27'(la);
    end else begin
      model_hits++;
    end
    r.is_read = !wr;
    r.rdata   = gold_word(wa);
    r.n_pmem  = n;
    r.hit     = hit;
    exp_resp.push_back(r);
    if (wr) begin
      w = gold_word(wa);
      for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wdata[i*8 +: 8];
      gold[wa] = w;
      m_dirty[set] = 1'b1;
    end

    @(posedge clk);
    #1;
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wdata;
    req_cyc   = cyc;
    pmem_base = pmem_done;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_resp && k < 200);
    if (!bus.mem_resp) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=no_resp required=mem_resp addr=%h", addr);
      finish_sim();
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {bus.mem_rdata, bus.pmem_address, 29'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write},
        256'd0);
  endtask

  task automatic reset_mid_alloc(input logic [31:0] addr);
    pmem_t p;
    p.is_write = 1'b0;
    p.addr     = {addr[31:5], 5'b00000};
    p.wdata    = '0;
    exp_pmem.push_back(p);
    force_lat = 20;
    @(posedge clk);
    #1;
    bus.mem_address = addr;
    bus.mem_read    = 1'b1;
    @(negedge clk);
    chk("miss_check_no_pmem", 256'(bus.pmem_read), 256'd0);
    @(negedge clk);
    chk("allocate_pmem_read", 256'(bus.pmem_read), 256'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk("rst_cycle_pmem_read", 256'(bus.pmem_read), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("after_abort_outputs", 256'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 256'd0);
    force_lat = 0;
    do_req(addr, 1'b1, 1'b0, 4'h0, 32'h0);
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic check_counters(input string tag);
    chk({tag, "_hit_count"}, 256'(hit_count), 256'(model_hits));
    chk({tag, "_miss_count"}, 256'(miss_count), 256'(model_misses));
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    int unsigned  tag, kind;

    rst = 1'b1;
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    repeat (2) @(posedge clk);
    apply_reset();

    // Directed: fill, partial write, dirty conflict eviction.
    l = pmem_line(2);
    l[31:0] = 32'hDEAD_BEEF;
    pmem_mem[2] = l;
    force_lat = 3;
    do_req(32'h0000_0040, 1'b1, 1'b0, 4'h0, 32'h0);
    force_lat = 0;
    do_req(32'h0000_0044, 1'b0, 1'b1, 4'b0011, 32'h1122_3344);
    do_req(32'h0000_0044, 1'b1, 1'b0, 4'h0, 32'h0);
`ifdef CACHE_PERF_CNT_EN
    check_counters("after_miss_hit_hit");
    chk("directed_hit_count_2", 256'(hit_count), 256'd2);
    chk("directed_miss_count_1", 256'(miss_count), 256'd1);
`endif
    do_req(32'h0000_0140, 1'b1, 1'b0, 4'h0, 32'h0);
    do_req(32'h0000_0040, 1'b1, 1'b0, 4'h0, 32'h0);
    // Byte enable 0000 still marks the line dirty.
    do_req(32'h0000_0060, 1'b0, 1'b1, 4'b0000, 32'hFFFF_FFFF);
    do_req(32'h0000_0160, 1'b1, 1'b1, 4'b1100, 32'hA5A5_5A5A);
    do_req(32'h0000_0060, 1'b1, 1'b0, 4'h0, 32'h0);

    apply_reset();
    reset_mid_alloc(32'h0000_0260);

    // Random traffic over a small tag pool so hits and conflicts are common.
    for (int n = 0; n < 300; n++) begin
      tag = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) tag = 32'h00FF_FFFC + tag;
      a = (tag << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      kind = $urandom_range(0, 2);
      do_req(a, kind != 1, kind != 0, 4'($urandom_range(0, 15)), $urandom);
      if (n == 150) apply_reset();
    end

    chk("exp_resp_drained", 256'(exp_resp.size()), 256'd0);
    chk("exp_pmem_drained", 256'(exp_pmem.size()), 256'd0);
`ifdef CACHE_PERF_CNT_EN
    check_counters("final");
`endif
    finish_sim();
  end

endmodule
